// File: rtl/instr_encoder.sv
// LEGv8 instruction assembler: range-checks request fields, packs them into
// R/D/CB/B format and streams them into instruction memory, one word per cycle.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [5:0]        shamt,
  input  logic [25:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  typedef enum logic {
    S_RUN,
    S_FULL
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         enc;
  logic                legal;
  logic                accept;
  logic                d_in_range;
  logic                cb_in_range;

  // A signed immediate fits N bits when every bit above N-1 copies the sign.
  assign d_in_range  = (imm[25:8]  == '0) || (imm[25:8]  == '1);
  assign cb_in_range = (imm[25:18] == '0) || (imm[25:18] == '1);

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op_sel)
      4'd0:    enc = {OPC_ADD, rm, 6'd0, rn, rd};
      4'd1:    enc = {OPC_SUB, rm, 6'd0, rn, rd};
      4'd2:    enc = {OPC_AND, rm, 6'd0, rn, rd};
      4'd3:    enc = {OPC_ORR, rm, 6'd0, rn, rd};
      4'd4:    enc = {OPC_LSL, 5'd0, shamt, rn, rd};
      4'd5:    enc = {OPC_LSR, 5'd0, shamt, rn, rd};
      4'd6: begin
        enc   = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        legal = d_in_range;
      end
      4'd7: begin
        enc   = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        legal = d_in_range;
      end
      4'd8: begin
        enc   = {OPC_CBZ, imm[18:0], rd};
        legal = cb_in_range;
      end
      4'd9:    enc = {OPC_B, imm};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      ptr_d   = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
        if (ptr_q == '1) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign err        = err_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign full       = (state_q == S_FULL);
  assign count      = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios followed by random
// traffic, checked against an arithmetic model of the LEGv8 encodings.
module tb_instr_encoder;

  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 1 << AW;

  logic          CLOCK = 1'b0;
  logic          RESET, clear, in_valid, in_ready;
  logic [3:0]    op_sel;
  logic [4:0]    rd, rn, rm;
  logic [5:0]    shamt;
  logic [25:0]   imm;
  logic          imem_we, err, full;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm),
    .shamt(shamt), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .err(err), .full(full), .count(count)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit        we;
    bit        er;
    bit [31:0] addr;
    bit [31:0] wdata;
  } exp_t;

  exp_t      sbq[$];
  int        checks = 0;
  int        errors = 0;
  bit        mon_en = 0;
  int        m_ptr = 0, m_cnt = 0;
  bit        m_full = 0;
  bit [31:0] m_last = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_legal(int op, int im);
    case (op)
      0, 1, 2, 3, 4, 5, 9: return 1;
      6, 7:                return (im >= -256) && (im <= 255);
      8:                   return (im >= -(1 << 18)) && (im < (1 << 18));
      default:             return 0;
    endcase
  endfunction

  function automatic longint wrapmod(int v, longint m);
    return ((longint'(v) % m) + m) % m;
  endfunction

  function automatic bit [31:0] m_enc(int op, int rd_, int rn_, int rm_, int sh, int im);
    longint opc, r;
    case (op)
      0: opc = 1112;  // 10001011000
      1: opc = 1624;  // 11001011000
      2: opc = 1104;  // 10001010000
      3: opc = 1360;  // 10101010000
      4: opc = 1691;  // 11010011011
      5: opc = 1690;  // 11010011010
      6: opc = 1986;  // 11111000010
      7: opc = 1984;  // 11111000000
      default: opc = 0;
    endcase
    if (op <= 3)
      r = opc * 2097152 + longint'(rm_) * 65536 + rn_ * 32 + rd_;
    else if (op <= 5)
      r = opc * 2097152 + longint'(sh) * 1024 + rn_ * 32 + rd_;
    else if (op <= 7)
      r = opc * 2097152 + wrapmod(im, 512) * 4096 + rn_ * 32 + rd_;
    else if (op == 8)
      r = longint'(180) * 16777216 + wrapmod(im, 524288) * 32 + rd_;
    else
      r = longint'(5) * 67108864 + wrapmod(im, 67108864);
    return r[31:0];
  endfunction

  task automatic cyc(bit v, int op, int rd_, int rn_, int rm_, int sh, int im,
                     bit clr = 0, bit rst = 0, bit ovr = 0, bit [31:0] ovr_w = 0);
    exp_t e;
    RESET    = rst;
    clear    = clr;
    in_valid = v;
    op_sel   = 4'(op);
    rd       = 5'(rd_);
    rn       = 5'(rn_);
    rm       = 5'(rm_);
    shamt    = 6'(sh);
    imm      = 26'(im);
    @(posedge CLOCK);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_full = 0; m_last = 0;
    end else if (clr) begin
      m_ptr = 0; m_cnt = 0; m_full = 0;
    end else if (v && !m_full) begin
      if (m_legal(op, im)) begin
        e.we    = 1;
        e.er    = 0;
        e.addr  = 32'(m_ptr);
        e.wdata = ovr ? ovr_w : m_enc(op, rd_, rn_, rm_, sh, im);
        m_last  = e.wdata;
        if (m_ptr == DEPTH - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_cnt++;
      end else begin
        e.we = 0; e.er = 1; e.addr = 0; e.wdata = 0;
      end
      sbq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(int n = 1);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_chk();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
  endtask

  // Monitor: one check set per cycle, popping the scoreboard on any output.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      if (mon_en) begin
        if (imem_we || err) begin
          if (sbq.size() == 0) begin
            chk("spurious_output", {30'd0, imem_we, err}, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("we", 32'(imem_we), 32'(e.we));
            chk("err", 32'(err), 32'(e.er));
            if (e.we) begin
              chk("addr", 32'(imem_addr), e.addr);
              chk("wdata", imem_wdata, e.wdata);
            end
          end
        end else if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("missing_output", 32'd0, {30'd0, e.we, e.er});
        end
        chk("full", 32'(full), 32'(m_full));
        chk("in_ready", 32'(in_ready), 32'(!m_full));
        chk("count", 32'(count), 32'(m_cnt));
        if (!imem_we) chk("wdata_hold", imem_wdata, m_last);
      end
    end
  end

  initial begin
    int op, im, sel;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    mon_en = 1;
    idle();
    @(negedge CLOCK);
    rst_chk();

    // Fill a 4-word memory; the fifth request lands while full.
    cyc(1, 0, 3, 1, 2, 5, 0, 0, 0, 1, 32'h8B020023);
    cyc(1, 6, 2, 10, 0, 0, 8, 0, 0, 1, 32'hF8408142);
    cyc(1, 8, 5, 0, 0, 0, -2, 0, 0, 1, 32'hB4FFFFC5);
    cyc(1, 9, 0, 0, 0, 0, 4, 0, 0, 1, 32'h14000004);
    cyc(1, 1, 7, 8, 9, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 3, 1, 2, 3, 0, 0);

    // Rejections leave pointer and count alone.
    cyc(1, 6, 2, 10, 0, 0, 300);
    cyc(1, 12, 1, 1, 1, 0, 0);
    cyc(1, 4, 4, 5, 6, 17, 0);
    cyc(1, 8, 1, 0, 0, 0, 1 << 18);
    cyc(1, 7, 3, 4, 0, 0, -256);
    idle();

    // RESET cancels a same-cycle accept.
    cyc(1, 2, 1, 2, 3, 0, 0, 0, 1);
    @(negedge CLOCK);
    rst_chk();
    cyc(1, 5, 9, 8, 7, 63, 0);

    // clear beats a same-cycle accept; pointer restarts at 0.
    cyc(1, 0, 1, 1, 1, 0, 0, 1);
    cyc(1, 9, 0, 0, 0, 0, -(1 << 25));
    idle();

    for (int i = 0; i < 600; i++) begin
      op  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       im = int'($urandom_range(0, 600)) - 300;
        1:       im = int'($urandom_range(0, (1 << 19) + 1000)) - ((1 << 18) + 500);
        2:       im = int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
        default: im = int'($urandom_range(0, 20)) - 10;
      endcase
      cyc($urandom_range(0, 3) != 0, op, $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 63), im,
          $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end
    idle(2);
    @(negedge CLOCK);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
